// File: rtl/ascon_pkg.sv
// Shared Ascon types, padder state encoding and small helper functions used by
// the stream padder and the AEAD/Hash datapath.
package ascon_pkg;

    typedef enum logic [2:0] {
        MODE_AEAD_ENC = 3'd0,
        MODE_AEAD_DEC = 3'd1,
        MODE_HASH     = 3'd2,
        MODE_XOF      = 3'd3,
        MODE_CXOF     = 3'd4
    } ascon_mode_t;

    typedef enum logic [2:0] {
        TUSER_KEY   = 3'd0,
        TUSER_NONCE = 3'd1,
        TUSER_AD    = 3'd2,
        TUSER_PT    = 3'd3,
        TUSER_CT    = 3'd4,
        TUSER_TAG   = 3'd5,
        TUSER_MSG   = 3'd6,
        TUSER_Z     = 3'd7
    } axi_tuser_t;

    typedef logic [1:0] padder_state_t;
    localparam padder_state_t ST_PASS = 2'd0;
    localparam padder_state_t ST_PADW = 2'd1;
    localparam padder_state_t ST_FILL = 2'd2;

    typedef enum logic [1:0] {
        GRP_PASS = 2'd0,
        GRP_PAD  = 2'd1,
        GRP_CT   = 2'd2
    } pad_group_t;

    localparam logic [7:0] ASCON_PAD_BYTE = 8'h01;

    function automatic logic [7:0] ascon_rate_bits(input ascon_mode_t mode);
        logic [7:0] rate;
        case (mode)
            MODE_AEAD_ENC, MODE_AEAD_DEC: rate = 8'd128;
            default:                      rate = 8'd64;
        endcase
        return rate;
    endfunction

    function automatic pad_group_t tuser_pad_group(input axi_tuser_t tuser);
        pad_group_t grp;
        case (tuser)
            TUSER_KEY, TUSER_NONCE, TUSER_TAG: grp = GRP_PASS;
            TUSER_CT:                          grp = GRP_CT;
            default:                           grp = GRP_PAD;
        endcase
        return grp;
    endfunction

    // A legal tkeep is a run of ones starting at lane 0 (or all zero).
    function automatic logic keep_contiguous(input logic [7:0] keep);
        return ((keep & (keep + 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/ascon_pad_mask.sv
// Combinational last-word formatter: keeps the first popcount(keep) byte lanes,
// writes the Ascon pad byte into the next lane and zeroes the rest.
module ascon_pad_mask
    import ascon_pkg::*;
#(
    parameter int KEEP_W = 8
) (
    input  logic [8*KEEP_W-1:0] data_i,
    input  logic [KEEP_W-1:0]   keep_i,
    output logic [8*KEEP_W-1:0] data_o
);

    localparam int LW = $clog2(KEEP_W + 1);

    logic [LW-1:0] n_s;

    // Count valid byte lanes.
    always_comb begin
        n_s = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            n_s = n_s + LW'(keep_i[i]);
        end
    end

    // A full word has no lane equal to n and therefore passes unchanged.
    always_comb begin
        data_o = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            if (LW'(i) < n_s) begin
                data_o[8*i +: 8] = data_i[8*i +: 8];
            end else if (LW'(i) == n_s) begin
                data_o[8*i +: 8] = ASCON_PAD_BYTE;
            end else begin
                data_o[8*i +: 8] = 8'h00;
            end
        end
    end

endmodule

// File: rtl/ascon_padder_gen.sv
// AXI4-Stream padder/rate-aligner with a registered output stage.
// Defining ASCON_PADDER_ERR_EN adds the sticky err_o protocol-violation flag.
module ascon_padder_gen
    import ascon_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int KEEP_W     = DATA_W / 8,
    parameter int MAX_RATE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  ascon_mode_t       mode_i,
    input  logic [DATA_W-1:0] s_axis_tdata_i,
    input  logic [KEEP_W-1:0] s_axis_tkeep_i,
    input  axi_tuser_t        s_axis_tuser_i,
    input  logic              s_axis_tlast_i,
    input  logic              s_axis_tvalid_i,
    output logic              s_axis_tready_o,
    output logic [DATA_W-1:0] padded_tdata_o,
    output logic [KEEP_W-1:0] padded_tkeep_o,
    output axi_tuser_t        padded_tuser_o,
    output logic              padded_tlast_o,
    output logic              padded_tvalid_o,
    input  logic              padded_tready_i
`ifdef ASCON_PADDER_ERR_EN
    ,
    output logic              err_o
`endif
);

    localparam int CNT_W = $clog2(MAX_RATE_W / DATA_W + 1);

    padder_state_t     state_q, state_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              in_pkt_q, in_pkt_d;
    ascon_mode_t       mode_q, mode_d;
    axi_tuser_t        tuser_q, tuser_d;
    logic [DATA_W-1:0] tdata_q, tdata_d;
    logic [KEEP_W-1:0] tkeep_q, tkeep_d;
    axi_tuser_t        otuser_q, otuser_d;
    logic              tlast_q, tlast_d;
    logic              tvalid_q, tvalid_d;

    logic              load_en_s;
    logic              accept_s;
    ascon_mode_t       blk_mode_s;
    axi_tuser_t        blk_tuser_s;
    logic [CNT_W-1:0]  last_idx_s;
    logic              cnt_last_s;
    logic [CNT_W-1:0]  cnt_next_s;
    logic [DATA_W-1:0] masked_s;

    ascon_pad_mask #(.KEEP_W(KEEP_W)) u_pad_mask (
        .data_i (s_axis_tdata_i),
        .keep_i (s_axis_tkeep_i),
        .data_o (masked_s)
    );

    assign load_en_s       = !tvalid_q || padded_tready_i;
    assign s_axis_tready_o = rst_n && load_en_s && (state_q == ST_PASS);
    assign accept_s        = s_axis_tready_o && s_axis_tvalid_i;

    // The first beat of a packet uses the live mode/tuser; later beats use the latched copy.
    always_comb begin
        if (state_q == ST_PASS && !in_pkt_q) begin
            blk_mode_s  = mode_i;
            blk_tuser_s = s_axis_tuser_i;
        end else begin
            blk_mode_s  = mode_q;
            blk_tuser_s = tuser_q;
        end
        last_idx_s = CNT_W'((int'(ascon_rate_bits(blk_mode_s)) / DATA_W) - 1);
        cnt_last_s = (beat_cnt_q == last_idx_s);
        cnt_next_s = cnt_last_s ? '0 : beat_cnt_q + CNT_W'(1);
    end

    // Next-state and output-word formation.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        in_pkt_d   = in_pkt_q;
        mode_d     = mode_q;
        tuser_d    = tuser_q;
        tdata_d    = tdata_q;
        tkeep_d    = tkeep_q;
        otuser_d   = otuser_q;
        tlast_d    = tlast_q;
        tvalid_d   = tvalid_q;
        case (state_q)
            ST_PASS: begin
                if (accept_s) begin
                    if (!in_pkt_q) begin
                        mode_d  = mode_i;
                        tuser_d = s_axis_tuser_i;
                    end else begin
                        mode_d  = mode_q;
                        tuser_d = tuser_q;
                    end
                    in_pkt_d = !s_axis_tlast_i;
                    tvalid_d = 1'b1;
                    otuser_d = blk_tuser_s;
                    tdata_d  = s_axis_tdata_i;
                    tkeep_d  = '1;
                    tlast_d  = 1'b0;
                    case (tuser_pad_group(blk_tuser_s))
                        GRP_PAD: begin
                            if (!s_axis_tlast_i) begin
                                beat_cnt_d = cnt_next_s;
                            end else if (&s_axis_tkeep_i) begin
                                beat_cnt_d = cnt_next_s;
                                state_d    = ST_PADW;
                            end else begin
                                tdata_d = masked_s;
                                if (cnt_last_s) begin
                                    tlast_d    = 1'b1;
                                    beat_cnt_d = '0;
                                end else begin
                                    beat_cnt_d = cnt_next_s;
                                    state_d    = ST_FILL;
                                end
                            end
                        end
                        GRP_CT: begin
                            tkeep_d = s_axis_tkeep_i;
                            tlast_d = s_axis_tlast_i;
                        end
                        default: begin
                            tlast_d = s_axis_tlast_i;
                        end
                    endcase
                end else if (load_en_s) begin
                    tvalid_d = 1'b0;
                end else begin
                    tvalid_d = tvalid_q;
                end
            end
            ST_PADW, ST_FILL: begin
                if (load_en_s) begin
                    tvalid_d = 1'b1;
                    tkeep_d  = '1;
                    otuser_d = tuser_q;
                    if (state_q == ST_PADW) begin
                        tdata_d = {{(DATA_W-8){1'b0}}, ASCON_PAD_BYTE};
                    end else begin
                        tdata_d = '0;
                    end
                    if (cnt_last_s) begin
                        tlast_d    = 1'b1;
                        beat_cnt_d = '0;
                        state_d    = ST_PASS;
                    end else begin
                        tlast_d    = 1'b0;
                        beat_cnt_d = cnt_next_s;
                        state_d    = ST_FILL;
                    end
                end else begin
                    tvalid_d = tvalid_q;
                end
            end
            default: begin
                state_d = ST_PASS;
            end
        endcase
    end

    // State and output register stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_PASS;
            beat_cnt_q <= '0;
            in_pkt_q   <= 1'b0;
            mode_q     <= MODE_AEAD_ENC;
            tuser_q    <= TUSER_KEY;
            tdata_q    <= '0;
            tkeep_q    <= '0;
            otuser_q   <= TUSER_KEY;
            tlast_q    <= 1'b0;
            tvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            in_pkt_q   <= in_pkt_d;
            mode_q     <= mode_d;
            tuser_q    <= tuser_d;
            tdata_q    <= tdata_d;
            tkeep_q    <= tkeep_d;
            otuser_q   <= otuser_d;
            tlast_q    <= tlast_d;
            tvalid_q   <= tvalid_d;
        end
    end

    assign padded_tdata_o  = tdata_q;
    assign padded_tkeep_o  = tkeep_q;
    assign padded_tuser_o  = otuser_q;
    assign padded_tlast_o  = tlast_q;
    assign padded_tvalid_o = tvalid_q;

`ifdef ASCON_PADDER_ERR_EN
    logic err_q, err_d;

    // Sticky flag for gapped tkeep on padded/CT beats and tuser changing mid-packet.
    always_comb begin
        err_d = err_q;
        if (accept_s && (tuser_pad_group(blk_tuser_s) != GRP_PASS)
                && !keep_contiguous(8'(s_axis_tkeep_i))) begin
            err_d = 1'b1;
        end else if (accept_s && in_pkt_q && (s_axis_tuser_i != tuser_q)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Error flag register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_ascon_padder_gen.sv
// Scoreboard bench for ascon_padder_gen: a 64-bit instance under random
// backpressure and a 32-bit instance, both checked against a reference model.
module tb_ascon_padder_gen;
    import ascon_pkg::*;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic [2:0]  tuser;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    ascon_mode_t mode_a;  logic [63:0] tdata_a; logic [7:0] tkeep_a; axi_tuser_t tuser_a;
    logic tlast_a, tvalid_a, tready_a;
    logic [63:0] pdata_a; logic [7:0] pkeep_a; axi_tuser_t ptuser_a;
    logic plast_a, pvalid_a;
    logic pready_a = 1'b1;

    ascon_mode_t mode_b;  logic [31:0] tdata_b; logic [3:0] tkeep_b; axi_tuser_t tuser_b;
    logic tlast_b, tvalid_b, tready_b;
    logic [31:0] pdata_b; logic [3:0] pkeep_b; axi_tuser_t ptuser_b;
    logic plast_b, pvalid_b;
    logic pready_b = 1'b1;

    ascon_padder_gen #(.DATA_W(64)) dut_a (
        .clk(clk), .rst_n(rst_n), .mode_i(mode_a),
        .s_axis_tdata_i(tdata_a), .s_axis_tkeep_i(tkeep_a), .s_axis_tuser_i(tuser_a),
        .s_axis_tlast_i(tlast_a), .s_axis_tvalid_i(tvalid_a), .s_axis_tready_o(tready_a),
        .padded_tdata_o(pdata_a), .padded_tkeep_o(pkeep_a), .padded_tuser_o(ptuser_a),
        .padded_tlast_o(plast_a), .padded_tvalid_o(pvalid_a), .padded_tready_i(pready_a)
    );

    ascon_padder_gen #(.DATA_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .mode_i(mode_b),
        .s_axis_tdata_i(tdata_b), .s_axis_tkeep_i(tkeep_b), .s_axis_tuser_i(tuser_b),
        .s_axis_tlast_i(tlast_b), .s_axis_tvalid_i(tvalid_b), .s_axis_tready_o(tready_b),
        .padded_tdata_o(pdata_b), .padded_tkeep_o(pkeep_b), .padded_tuser_o(ptuser_b),
        .padded_tlast_o(plast_b), .padded_tvalid_o(pvalid_b), .padded_tready_i(pready_b)
    );

    int    chk_cnt = 0;
    int    err_cnt = 0;
    beat_t exp_a[$];
    beat_t exp_b[$];
    int    mcnt[2];
    int    rdy_mode = 0;   // 0: always ready, 1: random, 2: never ready
    bit    skip_stab = 1'b0;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic beat_t mk(input logic [63:0] d, input logic [7:0] k, input int u, input bit l);
        beat_t b;
        b.data = d; b.keep = k; b.tuser = 3'(u); b.last = l;
        return b;
    endfunction

    task automatic push_exp(input int w, input beat_t b);
        if (w == 0) exp_a.push_back(b);
        else        exp_b.push_back(b);
    endtask

    // Reference model: expected output beats for one accepted input beat.
    task automatic model_beat(input int w, input logic [63:0] din, input logic [7:0] k,
                              input int u, input bit last, input int mode);
        int dw, kw, beats, n, c;
        logic [7:0]  kall;
        logic [63:0] d, md;
        dw    = (w == 0) ? 64 : 32;
        kw    = dw / 8;
        beats = ((mode <= 1) ? 128 : 64) / dw;
        kall  = (w == 0) ? 8'hFF : 8'h0F;
        d     = (w == 0) ? din : {32'h0, din[31:0]};
        if (u == int'(TUSER_KEY) || u == int'(TUSER_NONCE) || u == int'(TUSER_TAG)) begin
            push_exp(w, mk(d, kall, u, last));
        end else if (u == int'(TUSER_CT)) begin
            push_exp(w, mk(d, k & kall, u, last));
        end else if (!last) begin
            push_exp(w, mk(d, kall, u, 1'b0));
            mcnt[w] = (mcnt[w] + 1) % beats;
        end else begin
            n = 0;
            for (int i = 0; i < kw; i++) n += int'(k[i]);
            c = mcnt[w] + 1;
            if (n < kw) begin
                md = 64'h0;
                for (int i = 0; i < kw; i++) begin
                    if (i < n)       md[8*i +: 8] = d[8*i +: 8];
                    else if (i == n) md[8*i +: 8] = 8'h01;
                end
                push_exp(w, mk(md, kall, u, c == beats));
            end else begin
                push_exp(w, mk(d, kall, u, 1'b0));
                if (c == beats) c = 0;
                c++;
                push_exp(w, mk(64'h1, kall, u, c == beats));
            end
            while (c < beats) begin
                c++;
                push_exp(w, mk(64'h0, kall, u, c == beats));
            end
            mcnt[w] = 0;
        end
    endtask

    // Drive one beat from a negedge and wait (bounded) for its handshake.
    task automatic send_beat(input int w, input logic [63:0] d, input logic [7:0] k, input int u,
                             input bit last, input int mode, input int drive_mode);
        int waited = 0;
        bit done = 1'b0;
        bit rdy;
        if (w == 0) begin
            tdata_a = d; tkeep_a = k; tuser_a = axi_tuser_t'(u); tlast_a = last;
            mode_a = ascon_mode_t'(drive_mode); tvalid_a = 1'b1;
        end else begin
            tdata_b = d[31:0]; tkeep_b = k[3:0]; tuser_b = axi_tuser_t'(u); tlast_b = last;
            mode_b = ascon_mode_t'(drive_mode); tvalid_b = 1'b1;
        end
        while (!done && waited < 300) begin
            #1;
            rdy = (w == 0) ? tready_a : tready_b;
            if (rdy) begin
                model_beat(w, d, k, u, last, mode);
                @(negedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
                waited++;
            end
        end
        if (!done) check_value("handshake_timeout", 64'd0, 64'd1);
        if (w == 0) tvalid_a = 1'b0;
        else        tvalid_b = 1'b0;
    endtask

    task automatic rand_packet(input int w);
        int u, mode, len, kw;
        logic [7:0] kall, k;
        kw   = (w == 0) ? 8 : 4;
        kall = (w == 0) ? 8'hFF : 8'h0F;
        u    = $urandom_range(0, 7);
        mode = $urandom_range(0, 4);
        len  = $urandom_range(1, 5);
        for (int j = 0; j < len; j++) begin
            k = (j == len - 1) ? (kall >> $urandom_range(0, kw)) : kall;
            send_beat(w, {$urandom, $urandom}, k, u, j == len - 1, mode,
                      (j == 0) ? mode : int'($urandom_range(0, 4)));
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_value("drain_a", 64'(exp_a.size()), 64'd0);
        check_value("drain_b", 64'(exp_b.size()), 64'd0);
    endtask

    // 64-bit output monitor: sets backpressure, checks hold-while-stalled and scoreboard.
    logic        prev_stall_a = 1'b0;
    logic [63:0] prev_data_a;
    logic [7:0]  prev_keep_a;
    logic        prev_last_a;
    always @(negedge clk) begin
        beat_t e;
        pready_a = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : (rdy_mode == 0);
        if (prev_stall_a && !skip_stab) begin
            check_value("stall_valid", 64'(pvalid_a), 64'd1);
            check_value("stall_data", pdata_a, prev_data_a);
            check_value("stall_keep", 64'(pkeep_a), 64'(prev_keep_a));
            check_value("stall_last", 64'(plast_a), 64'(prev_last_a));
        end
        if (rst_n && pvalid_a && pready_a) begin
            if (exp_a.size() == 0) begin
                check_value("a_unexpected_beat", 64'd1, 64'd0);
            end else begin
                e = exp_a.pop_front();
                check_value("a_data", pdata_a, e.data);
                check_value("a_keep", 64'(pkeep_a), 64'(e.keep));
                check_value("a_tuser", 64'(ptuser_a), 64'(e.tuser));
                check_value("a_last", 64'(plast_a), 64'(e.last));
            end
        end
        prev_stall_a = pvalid_a && !pready_a;
        prev_data_a  = pdata_a;
        prev_keep_a  = pkeep_a;
        prev_last_a  = plast_a;
    end

    // 32-bit output monitor (always ready).
    always @(negedge clk) begin
        beat_t e;
        if (rst_n && pvalid_b && pready_b) begin
            if (exp_b.size() == 0) begin
                check_value("b_unexpected_beat", 64'd1, 64'd0);
            end else begin
                e = exp_b.pop_front();
                check_value("b_data", 64'(pdata_b), e.data);
                check_value("b_keep", 64'(pkeep_b), 64'(e.keep));
                check_value("b_tuser", 64'(ptuser_b), 64'(e.tuser));
                check_value("b_last", 64'(plast_b), 64'(e.last));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        mode_a = MODE_AEAD_ENC; tdata_a = '0; tkeep_a = '0; tuser_a = TUSER_KEY; tlast_a = 1'b0; tvalid_a = 1'b0;
        mode_b = MODE_AEAD_ENC; tdata_b = '0; tkeep_b = '0; tuser_b = TUSER_KEY; tlast_b = 1'b0; tvalid_b = 1'b0;
        mcnt[0] = 0; mcnt[1] = 0;
        repeat (3) @(negedge clk);
        check_value("rst_tvalid", 64'(pvalid_a), 64'd0);
        check_value("rst_tdata", pdata_a, 64'd0);
        check_value("rst_tlast", 64'(plast_a), 64'd0);
        check_value("rst_tready", 64'(tready_a), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_value("idle_tready", 64'(tready_a), 64'd1);
        @(negedge clk);

        // AEAD AD, 3 valid bytes: masked word then one zero fill word; upstream stalls one cycle.
        send_beat(0, 64'h1122_3344_55AA_BBCC, 8'h07, int'(TUSER_AD), 1'b1, 0, 0);
        #1;
        check_value("fill_tready_low", 64'(tready_a), 64'd0);
        @(negedge clk);
        #1;
        check_value("fill_tready_back", 64'(tready_a), 64'd1);
        @(negedge clk);
        // Hash MSG, full word: data then dedicated pad word.
        send_beat(0, 64'hDEAD_BEEF_0123_4567, 8'hFF, int'(TUSER_MSG), 1'b1, 2, 2);
        // CT last beat with partial keep passes through unchanged.
        send_beat(0, 64'h0102_0304_0506_0708, 8'h0F, int'(TUSER_CT), 1'b1, 0, 0);
        // 32-bit AEAD PT empty message: 0x01 then three zero words.
        send_beat(1, 64'hCAFE_F00D, 8'h00, int'(TUSER_PT), 1'b1, 1, 1);
        // 32-bit Hash: full last word in second half of block.
        send_beat(1, 64'h1111_2222, 8'h0F, int'(TUSER_MSG), 1'b0, 2, 2);
        send_beat(1, 64'h3333_4444, 8'h0F, int'(TUSER_MSG), 1'b1, 2, 2);
        wait_drain();

        rdy_mode = 1;
        for (int p = 0; p < 100; p++) rand_packet(0);
        rdy_mode = 0;
        for (int p = 0; p < 30; p++) rand_packet(1);
        wait_drain();

        // Reset while the FILL word is stalled behind a held output.
        rdy_mode = 2;
        skip_stab = 1'b1;
        @(negedge clk);
        send_beat(0, 64'h0000_0000_0000_00AB, 8'h01, int'(TUSER_AD), 1'b1, 0, 0);
        @(negedge clk);
        check_value("fill_held_valid", 64'(pvalid_a), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_value("midfill_rst_tvalid", 64'(pvalid_a), 64'd0);
        check_value("midfill_rst_tready", 64'(tready_a), 64'd0);
        rst_n = 1'b1;
        exp_a.delete();
        mcnt[0] = 0;
        @(negedge clk);
        #1;
        check_value("post_rst_pass", 64'(tready_a), 64'd1);
        rdy_mode = 0;
        @(negedge clk);
        skip_stab = 1'b0;
        send_beat(0, 64'h0000_0000_0000_5566, 8'h02, int'(TUSER_PT), 1'b1, 0, 0);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/ascon_padder_gen.md
Name: ascon_padder_gen

Overview:
Parametrised AXI4-Stream padder/rate-aligner for the Ascon accelerator, sitting between the external slave stream and the top-level mux feeding the AEAD/Hash FSMs. It generalises the 64-bit padder to a configurable bus width (32 or 64 bits) and per-mode rate (64 or 128 bits). It injects the Ascon 0x01 padding byte, emits a dedicated padding word when the final word is full, and zero-fills to the rate boundary. Outputs are registered so the block also acts as a pipeline stage.

Parameters:
DATA_W, 64, stream data width in bits; legal values 32 or 64.
KEEP_W, DATA_W/8, tkeep width; derived, not overridden.
MAX_RATE_W, 128, largest rate in bits; sizes the beat counter.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
mode_i  in  ascon_mode_t  operating mode; latched on the first beat of each packet
s_axis_tdata_i  in  DATA_W  raw data
s_axis_tkeep_i  in  KEEP_W  byte enables; contiguous from lane 0
s_axis_tuser_i  in  axi_tuser_t  packet class
s_axis_tlast_i  in  1  last raw word of packet
s_axis_tvalid_i  in  1  raw valid
s_axis_tready_o  out  1  raw ready
padded_tdata_o  out  DATA_W  formatted data
padded_tkeep_o  out  KEEP_W  all ones, except raw tkeep passed through for TUSER_CT
padded_tuser_o  out  axi_tuser_t  tuser of the packet
padded_tlast_o  out  1  high only on the rate-aligned final beat
padded_tvalid_o  out  1  output valid
padded_tready_i  in  1  downstream ready

Behaviour:
- Reset (rst_n=0 at posedge): state=PASS; beat_cnt=0; padded_tvalid_o=0; padded_tdata/tkeep/tuser/tlast=0; s_axis_tready_o=0 while in reset. Reset mid-packet discards the packet and the held output word.
- Output register: load_en = !padded_tvalid_o || padded_tready_i. Data out has 1-cycle latency; sustained throughput is 1 word/cycle.
- s_axis_tready_o = load_en && state==PASS.
- Rate: RATE_W = 128 for AEAD modes, 64 for Hash/XOF/CXOF. BEATS = RATE_W/DATA_W (1, 2 or 4). beat_cnt wraps at BEATS and clears on every emitted tlast.
- Group A (KEY, NONCE, TAG) and Group C (CT): pass through unchanged. tkeep forced to all ones for Group A; raw tkeep kept for CT. tlast is copied. beat_cnt is not used.
- Group B (AD, PT, MSG, Z), non-last beat: data passes through, tkeep all ones, tlast=0, beat_cnt++.
- Group B, last beat, n = popcount(tkeep) with n<KEEP_W: lanes >= n are zeroed and lane n is set to 0x01. Byte lane i is tdata[8i+7:8i] (little-endian). If beat_cnt==BEATS-1, tlast=1; otherwise go to FILL.
- Group B, last beat, n==KEEP_W: word passes unchanged with tlast=0, then go to PADW.
- Empty message: tlast with tkeep=0 is treated as n=0, giving word 0x01.
- PADW: emit word 0x..01 (lane 0 = 0x01, rest 0). If the block is now full, assert tlast and go to PASS; otherwise go to FILL.
- FILL: emit all-zero words until beat_cnt==BEATS-1; that beat has tlast=1, then go to PASS.
- Upstream is stalled (tready=0) throughout PADW and FILL.
- Backpressure: while padded_tvalid_o && !padded_tready_i, all outputs hold stable and state does not advance.
- Mode and tuser latched on the first beat are used for the whole packet. Changes to mode_i mid-packet are ignored.

Optional Feature:
ASCON_PADDER_ERR_EN defined adds output err_o (1 bit, reset 0, sticky until reset). It sets on either of:
- non-contiguous s_axis_tkeep_i on an accepted Group B/CT beat;
- s_axis_tuser_i changing mid-packet.
Offending data is still forwarded. When the macro is undefined, the port is absent and no check logic is built.

Decomposition:
- Add to ascon_pkg:
  - padder_state_t {PASS, PADW, FILL};
  - function ascon_rate_bits(ascon_mode_t) returning 64 or 128;
  - function tuser_pad_group(axi_tuser_t) returning PASS/PAD/CT;
  - constant ASCON_PAD_BYTE = 8'h01.
- One sub-module, ascon_pad_mask: combinational; takes tdata and tkeep, returns the masked data with 0x01 inserted. Reusable by the AEAD decrypt path.

Test Plan:
- DATA_W=64, AEAD, AD one word with tkeep=0x07 and tdata=0x..AABBCC → word1 0x0000_0000_01AA_BBCC with tlast=0, then word2 0x0 with tlast=1; tready low for 1 cycle.
- DATA_W=64, Hash, MSG one full word (tkeep=0xFF) → data word with tlast=0, then 0x0000_0000_0000_0001 with tlast=1.
- DATA_W=32, AEAD, PT tlast with tkeep=0x0 as first beat → 0x00000001, then 3 zero words; tlast only on the 4th.
- DATA_W=64, CT last beat with tkeep=0x0F → data and tkeep=0x0F unchanged, tlast=1, no extra beats.
- Random padded_tready_i (50%) over 100 mixed packets → output stream matches the golden model; outputs stay stable while stalled.
- Assert rst_n=0 mid-FILL → next cycle tvalid=0 and state=PASS; the following packet is formatted correctly.
